// File: rtl/clk_div_pkg.sv
// Shared opcodes, command field layout and reset defaults for the clk_div_bank divider bank.
package clk_div_pkg;

  localparam int CMD_W = 24;

  localparam logic [1:0] OP_SET_PERIOD = 2'd0;
  localparam logic [1:0] OP_SET_LOW    = 2'd1;
  localparam logic [1:0] OP_SET_ENABLE = 2'd2;
  localparam logic [1:0] OP_SYNC       = 2'd3;

  localparam int OP_MSB  = 23;
  localparam int OP_LSB  = 22;
  localparam int CH_MSB  = 21;
  localparam int CH_LSB  = 18;
  localparam int VAL_MSB = 15;
  localparam int VAL_LSB = 0;

  // Legacy power-up behaviour: divide-by-3 with a 0,1,1 waveform.
  localparam int RST_PERIOD = 2;
  localparam int RST_LOW    = 1;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  ch;
    logic [15:0] value;
  } cmd_t;

  function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
    cmd_t c;
    c.op    = raw[OP_MSB:OP_LSB];
    c.ch    = raw[CH_MSB:CH_LSB];
    c.value = raw[VAL_MSB:VAL_LSB];
    return c;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: wrapping counter, double-buffered period, low-count compare,
// registered dclk/tick outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr_period,
  input  logic             i_wr_low,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_dclk,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_low;
  logic             r_dclk;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_period);

  // Counter update happens before the register writes so that a command landing
  // on the wrap cycle sees the wrap resolved first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_period <= CNT_W'(RST_PERIOD);
      r_shadow <= CNT_W'(RST_PERIOD);
      r_low    <= CNT_W'(RST_LOW);
      r_dclk   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      if (i_sync) begin
        r_cnt    <= '0;
        r_period <= r_shadow;
        r_dclk   <= 1'b0;
        r_tick   <= 1'b0;
      end else if (!i_en) begin
        r_cnt  <= '0;
        r_dclk <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        r_dclk <= (r_cnt >= r_low);
        r_tick <= w_wrap;
        if (w_wrap) r_period <= r_shadow;
      end
      if (i_wr_period) r_shadow <= i_value;
      if (i_wr_low)    r_low    <= i_value;
    end
  end

  assign o_dclk = r_dclk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of CHANNELS programmable clock dividers behind a single-strobe command port.
// Optional channel-0 wrap interrupt enabled by defining CLK_DIV_BANK_IRQ_EN.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CMD_W-1:0]    in,
  output logic                rdy,
  output logic                err,
  output logic [CHANNELS-1:0] dclk,
  output logic [CHANNELS-1:0] tick,
  output logic                irq
);

  cmd_t                w_cmd;
  logic                w_ch_bad;
  logic                w_is_chan_op;
  logic [CNT_W-1:0]    w_value;
  logic [CHANNELS-1:0] w_en_next;
  logic [CHANNELS-1:0] w_sync_mask;
  logic [CHANNELS-1:0] r_en;
  logic                r_rdy;
  logic                r_err;

  assign w_cmd        = unpack_cmd(in);
  assign w_ch_bad     = (32'(w_cmd.ch) >= CHANNELS);
  assign w_is_chan_op = (w_cmd.op == OP_SET_PERIOD) || (w_cmd.op == OP_SET_LOW);
  assign w_value      = w_cmd.value[CNT_W-1:0];

  // Channels run on the post-command enable so a disable clears them on the same edge.
  assign w_en_next   = (start && w_cmd.op == OP_SET_ENABLE) ? w_cmd.value[CHANNELS-1:0] : r_en;
  assign w_sync_mask = (start && w_cmd.op == OP_SYNC) ? w_cmd.value[CHANNELS-1:0] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en  <= '1;
      r_rdy <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_en  <= w_en_next;
      r_rdy <= start;
      r_err <= start && w_is_chan_op && w_ch_bad;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic w_sel;
      assign w_sel = start && !w_ch_bad && (32'(w_cmd.ch) == gi);

      clk_div_chan #(.CNT_W(CNT_W)) u_chan (
        .clk        (clk),
        .rst_n      (rst),
        .i_en       (w_en_next[gi]),
        .i_sync     (w_sync_mask[gi]),
        .i_wr_period(w_sel && (w_cmd.op == OP_SET_PERIOD)),
        .i_wr_low   (w_sel && (w_cmd.op == OP_SET_LOW)),
        .i_value    (w_value),
        .o_dclk     (dclk[gi]),
        .o_tick     (tick[gi])
      );
    end
  endgenerate

  assign rdy = r_rdy;
  assign err = r_err;

`ifdef CLK_DIV_BANK_IRQ_EN
  assign irq = tick[0];
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: spec-level model, per-cycle compare, directed and random commands.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic [23:0]   in    = '0;
  logic          rdy, err, irq;
  logic [CH-1:0] dclk, tick;

  clk_div_bank #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in   (in),
    .rdy  (rdy),
    .err  (err),
    .dclk (dclk),
    .tick (tick),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          m_cnt[CH];
  int          m_p[CH];
  int          m_ps[CH];
  int          m_l[CH];
  bit [CH-1:0] m_en;
  bit [CH-1:0] m_dclk;
  bit [CH-1:0] m_tick;
  bit          m_rdy;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a period-(P+1) counter; outputs describe the cycle just left.
  always @(posedge clk or negedge rst) begin : model
    int          n_cnt[CH];
    int          n_p[CH];
    int          n_ps[CH];
    int          n_l[CH];
    bit [CH-1:0] n_en;
    bit [CH-1:0] n_dclk;
    bit [CH-1:0] n_tick;
    int          op;
    int          ch;
    int          v;
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        n_cnt[i] = 0; n_p[i] = 2; n_ps[i] = 2; n_l[i] = 1;
      end
      n_en = '1; n_dclk = '0; n_tick = '0;
      m_rdy <= 1'b0;
      m_err <= 1'b0;
    end else begin
      op = int'(in[23:22]);
      ch = int'(in[21:18]);
      v  = int'(in[15:0]) % (1 << W);
      n_en = m_en;
      if (start && op == 2) n_en = in[CH-1:0];
      for (int i = 0; i < CH; i++) begin
        n_cnt[i] = m_cnt[i]; n_p[i] = m_p[i]; n_ps[i] = m_ps[i]; n_l[i] = m_l[i];
        if (start && op == 3 && in[i]) begin
          n_cnt[i] = 0; n_p[i] = m_ps[i]; n_dclk[i] = 1'b0; n_tick[i] = 1'b0;
        end else if (!n_en[i]) begin
          n_cnt[i] = 0; n_dclk[i] = 1'b0; n_tick[i] = 1'b0;
        end else begin
          n_dclk[i] = (m_cnt[i] >= m_l[i]);
          n_tick[i] = (m_cnt[i] == m_p[i]);
          if (n_tick[i]) begin
            n_cnt[i] = 0; n_p[i] = m_ps[i];
          end else begin
            n_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (start && ch == i && op == 0) n_ps[i] = v;
        if (start && ch == i && op == 1) n_l[i]  = v;
      end
      m_rdy <= start;
      m_err <= start && (op < 2) && (ch >= CH);
    end
    m_cnt  <= n_cnt;
    m_p    <= n_p;
    m_ps   <= n_ps;
    m_l    <= n_l;
    m_en   <= n_en;
    m_dclk <= n_dclk;
    m_tick <= n_tick;
  end

  always @(negedge clk) begin
    chk("dclk", 32'(dclk), 32'(m_dclk));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("rdy", 32'(rdy), 32'(m_rdy));
    chk("err", 32'(err), 32'(m_err));
`ifdef CLK_DIV_BANK_IRQ_EN
    chk("irq", 32'(irq), 32'(m_tick[0]));
`else
    chk("irq", 32'(irq), 32'h0);
`endif
  end

  task automatic cmd(input int op, input int ch, input int val);
    start = 1'b1;
    in    = {2'(op), 4'(ch), 2'b00, 16'(val)};
    @(negedge clk);
    start = 1'b0;
    in    = '0;
  endtask

  initial begin
    int hi;
    int tk;
    int op;
    int ch;
    int val;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, dclk, tick[0]}, 32'h0);
    chk("reset_flags", {29'd0, rdy, err, irq}, 32'h0);
    #2 rst = 1'b1;

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("legacy_dclk", 32'(dclk), (k % 3 == 0) ? 32'h0 : 32'hF);
      chk("legacy_tick", 32'(tick), (k % 3 == 2) ? 32'hF : 32'h0);
    end

    cmd(1, 12, 3);
    chk("bad_ch_rdy_err", {30'd0, rdy, err}, 32'h3);
    @(negedge clk);
    chk("bad_ch_pulse_end", {30'd0, rdy, err}, 32'h0);

    cmd(0, 1, 9);
    chk("set_period_rdy", {30'd0, rdy, err}, 32'h2);
    cmd(1, 1, 5);
    chk("set_low_rdy", {30'd0, rdy, err}, 32'h2);
    repeat (40) @(negedge clk);
    hi = 0; tk = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      hi += int'(dclk[1]);
      tk += int'(tick[1]);
    end
    chk("ch1_high_cycles", 32'(hi), 32'd5);
    chk("ch1_ticks", 32'(tk), 32'd1);

    cmd(2, 0, 5);
    cmd(3, 0, 15);
    tk = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("disabled_quiet", {28'd0, tick[3], tick[1], dclk[3], dclk[1]}, 32'h0);
      chk("sync_aligned", 32'(tick[2]), 32'(tick[0]));
      tk += int'(tick[0]);
    end
    chk("sync_ch0_ticks", 32'(tk), 32'd4);
    cmd(2, 0, 15);

    cmd(0, 0, 4);
    cmd(3, 0, 1);
    hi = 0; tk = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hi += int'(irq);
      tk += int'(tick[0]);
    end
    chk("p4_ch0_ticks", 32'(tk), 32'd4);
`ifdef CLK_DIV_BANK_IRQ_EN
    chk("irq_pulses", 32'(hi), 32'd4);
`else
    chk("irq_pulses", 32'(hi), 32'd0);
`endif

    start = 1'b1;
    in    = {2'd1, 4'd0, 2'b00, 16'd0};
    #2 rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in    = '0;
    chk("abort_no_rdy", 32'(rdy), 32'h0);
    #2 rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 35) begin
        op = int'($urandom_range(0, 3));
        ch = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
        case (op)
          0:       val = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 8));
          1:       val = int'($urandom_range(0, 10));
          2:       val = ($urandom_range(0, 3) == 0) ? int'($urandom) : 15;
          default: val = int'($urandom);
        endcase
        cmd(op, ch, val);
      end else begin
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, counter/period width in bits (2..16).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle command strobe.
REQ-006 SHALL have port in  input  24  command: [23:22] opcode, [21:18] channel, [15:0] value.
REQ-007 SHALL have port rdy  output  1  one-cycle pulse when a command is applied.
REQ-008 SHALL have port err  output  1  one-cycle pulse, together with rdy, when a command is rejected.
REQ-009 SHALL have port dclk  output  CHANNELS  registered divided waveform per channel.
REQ-010 SHALL have port tick  output  CHANNELS  registered one-cycle pulse per channel period wrap.
REQ-011 SHALL have port irq  output  1  channel-0 wrap interrupt pulse (see Configuration).

Function
REQ-012 Each channel SHALL hold cnt, active period P, shadow period Ps, low count L and enable bit.
REQ-013 Enabled channel: cnt SHALL increment each cycle; at cnt==P it SHALL wrap to 0 (divide ratio P+1).
REQ-014 dclk[i] SHALL equal, one cycle later, (cnt>=L); L=0 gives constant 1; L>P gives constant 0.
REQ-015 tick[i] SHALL assert for exactly the one cycle after cnt==P; P=0 SHALL give tick every cycle.
REQ-016 Opcode 0 (SET_PERIOD) SHALL write Ps; P SHALL load from Ps only on the wrap cycle, so a shorter period never truncates the current period.
REQ-017 Opcode 1 (SET_LOW) SHALL write L immediately.
REQ-018 Opcode 2 (SET_ENABLE) SHALL write the enable mask from value[CHANNELS-1:0]; the channel field is ignored.
REQ-019 Opcode 3 (SYNC) SHALL, for every channel set in value[CHANNELS-1:0], force cnt=0, load P from Ps and clear dclk/tick in the same cycle, phase-aligning them.
REQ-020 Disabled channel SHALL hold cnt=0, dclk=0, tick=0; on re-enable it SHALL start at cnt=0.
REQ-021 Command latency: state updated on the edge after start; rdy SHALL pulse on that same edge, one cycle after start.
REQ-022 Back-to-back start on consecutive cycles SHALL each be applied in order; no command is dropped.
REQ-023 Channel index >= CHANNELS on opcodes 0/1 SHALL change nothing and pulse err with rdy.
REQ-024 Value bits above CNT_W SHALL be ignored (truncated).
REQ-025 A command hitting a channel on its wrap cycle SHALL be resolved as: wrap first, then the write; a SYNC overrides the wrap.

Reset
REQ-026 While rst=0: all cnt=0, P=Ps=2, L=1, all channels enabled, dclk=0, tick=0, rdy=0, err=0, irq=0; this reproduces the legacy 0,1,1 divide-by-3 pattern.
REQ-027 Reset asserted mid-operation SHALL abort any command in flight; no rdy pulse follows.

Configuration
REQ-028 Macro CLK_DIV_BANK_IRQ_EN defined: irq SHALL pulse one cycle coincident with tick[0] while channel 0 is enabled.
REQ-029 Macro undefined: irq SHALL be tied to 0 and no irq logic synthesised; port list unchanged.

Structure
REQ-030 Package clk_div_pkg SHALL hold opcode constants, command field positions and reset defaults (P=2, L=1).
REQ-031 Per-channel counter/compare logic SHALL be sub-module clk_div_chan, instantiated CHANNELS times.

Verification
REQ-032 Reset release, no commands -> every dclk shows repeating 0,1,1; tick every 3rd cycle.
REQ-033 SET_PERIOD ch1 = 9, SET_LOW ch1 = 5 -> after current period ends, ch1 period 10 cycles, dclk 5 low / 5 high; rdy pulses 1 cycle after each start.
REQ-034 SET_PERIOD ch0 = 1 while cnt=2 of period 2 -> ch0 completes cnt 2 and then runs divide-by-2.
REQ-035 SET_ENABLE 0b0101, then SYNC 0b1111 -> ch1/ch3 dclk=0, tick=0; ch0/ch2 ticks aligned to the same cycle.
REQ-036 SET_LOW with channel 12 at CHANNELS=4 -> rdy and err both pulse; all channel state unchanged.
REQ-037 Build with CLK_DIV_BANK_IRQ_EN, ch0 period 4 -> irq pulses every 5 cycles; build without it -> irq stays 0.
